stop_it_controller: RTL



---
 rtl/stop_it_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stop_it_controller.sv
// Stop-It game FSM: target latch, counter reload/enable, grading, score and flash/won indication.
// Optional macro STOP_IT_TIMEOUT_EN: a round ends as WRONG when the counter reaches 0 with no press.
module stop_it_controller #(
    parameter int START_CYCLES  = 8,
    parameter int RESULT_CYCLES = 16,
    parameter int WIN_SCORE     = 15
) (
    input  logic       clk_4_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic [4:0] rand_i,
    input  logic [4:0] count_i,
    output logic       game_en_o,
    output logic       game_rst_no,
    output logic [4:0] target_o,
    output logic [3:0] score_o,
    output logic       flash_o,
    output logic       won_o
);

    typedef enum logic [2:0] {
        S_WAIT_TO_START,
        S_STARTING,
        S_DECREMENTING,
        S_CORRECT,
        S_WRONG,
        S_WON
    } state_t;

    localparam logic [4:0] START_LAST  = 5'(START_CYCLES - 1);
    localparam logic [4:0] RESULT_LAST = 5'(RESULT_CYCLES - 1);
    localparam logic [3:0] WIN_VALUE   = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [4:0] target_q, target_d;
    logic [3:0] score_q, score_d;
    logic [4:0] timer_q;
    logic       timeout;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_WAIT_TO_START;
            target_q <= 5'd0;
            score_q  <= 4'd0;
            timer_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            score_q  <= score_d;
            timer_q  <= (state_d != state_q) ? 5'd0 : timer_q + 5'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        score_d     = score_q;
        game_en_o   = 1'b0;
        game_rst_no = 1'b1;
        flash_o     = 1'b0;
        won_o       = 1'b0;
`ifdef STOP_IT_TIMEOUT_EN
        timeout     = (count_i == 5'd0);
`else
        timeout     = 1'b0;
`endif

        case (state_q)
            S_WAIT_TO_START: begin
                game_rst_no = 1'b0;
                if (go_i) begin
                    state_d  = S_STARTING;
                    target_d = rand_i;
                end
            end
            S_STARTING: begin
                game_rst_no = 1'b0;
                if (timer_q == START_LAST) state_d = S_DECREMENTING;
            end
            S_DECREMENTING: begin
                // Holding the enable low on the press edge keeps the graded value on display.
                game_en_o = ~go_i & ~timeout;
                if (go_i) begin
                    if (count_i == target_q) begin
                        state_d = S_CORRECT;
                        score_d = sat_inc(score_q);
                    end else begin
                        state_d = S_WRONG;
                    end
                end else if (timeout) begin
                    state_d = S_WRONG;
                end
            end
            S_CORRECT: begin
                flash_o = ~timer_q[0];
                if (timer_q == RESULT_LAST) begin
                    if (score_q == WIN_VALUE) begin
                        state_d = S_WON;
                    end else begin
                        state_d  = S_STARTING;
                        target_d = rand_i;
                    end
                end
            end
            S_WRONG: begin
                if (timer_q == RESULT_LAST) state_d = S_WAIT_TO_START;
            end
            S_WON: begin
                flash_o = 1'b1;
                won_o   = 1'b1;
                if (go_i) begin
                    state_d = S_WAIT_TO_START;
                    score_d = 4'd0;
                end
            end
            default: state_d = S_WAIT_TO_START;
        endcase
    end

    assign target_o = target_q;
    assign score_o  = score_q;

endmodule
